// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: H cycles high, L cycles low, N pulses or continuous.
// Define PULSE_GEN_DELAY_EN to add a delay_cycles port and a start-delay phase.
module pulse_gen #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] high_cycles,
   input  logic [CNT_W-1:0] low_cycles,
   input  logic [NUM_W-1:0] num_pulses,
`ifdef PULSE_GEN_DELAY_EN
   input  logic [CNT_W-1:0] delay_cycles,
`endif
   output logic             trig,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] pulse_cnt
);

`ifdef PULSE_GEN_DELAY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, DELAY = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [NUM_W-1:0] num_q, num_d;
   logic [NUM_W-1:0] pulse_cnt_d;
   logic             trig_d, busy_d, done_d;

   // Phase counters hold "cycles remaining minus one"; a zero length runs as one cycle.
   function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : len - CNT_W'(1);
   endfunction

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      high_d      = high_q;
      low_d       = low_q;
      num_d       = num_q;
      pulse_cnt_d = pulse_cnt;
      trig_d      = trig;
      done_d      = 1'b0;

      if (stop) begin
         state_d = IDLE;
         trig_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  high_d      = high_cycles;
                  low_d       = low_cycles;
                  num_d       = num_pulses;
                  pulse_cnt_d = NUM_W'(1);
                  state_d     = HIGH;
                  cnt_d       = len_m1(high_cycles);
                  trig_d      = 1'b1;
`ifdef PULSE_GEN_DELAY_EN
                  // No high phase has started yet while the delay runs.
                  if (delay_cycles != '0) begin
                     pulse_cnt_d = '0;
                     state_d     = DELAY;
                     cnt_d       = delay_cycles - CNT_W'(1);
                     trig_d      = 1'b0;
                  end
`endif
               end
            end

`ifdef PULSE_GEN_DELAY_EN
            DELAY: begin
               if (cnt_q == '0) begin
                  state_d     = HIGH;
                  cnt_d       = len_m1(high_q);
                  trig_d      = 1'b1;
                  pulse_cnt_d = NUM_W'(1);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
`endif

            HIGH: begin
               if (cnt_q == '0) begin
                  trig_d = 1'b0;
                  // The final pulse ends straight into IDLE, with no trailing low phase.
                  if ((num_q != '0) && (pulse_cnt == num_q)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = LOW;
                     cnt_d   = len_m1(low_q);
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end

            LOW: begin
               if (cnt_q == '0) begin
                  state_d     = HIGH;
                  cnt_d       = len_m1(high_q);
                  trig_d      = 1'b1;
                  pulse_cnt_d = pulse_cnt + NUM_W'(1);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end

            default: begin
               state_d = IDLE;
               trig_d  = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         high_q    <= '0;
         low_q     <= '0;
         num_q     <= '0;
         pulse_cnt <= '0;
         trig      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         high_q    <= high_d;
         low_q     <= low_d;
         num_q     <= num_d;
         pulse_cnt <= pulse_cnt_d;
         trig      <= trig_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the phase-length inputs and counters.
REQ-002 The block SHALL have parameter NUM_W, default 16, giving the width of the pulse-count input and counter.
REQ-003 clk  input  1  counting-domain clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a pulse train.
REQ-006 stop  input  1  abort the train in progress.
REQ-007 high_cycles  input  CNT_W  high-phase length in clk cycles.
REQ-008 low_cycles  input  CNT_W  low-phase length in clk cycles.
REQ-009 num_pulses  input  NUM_W  pulses per train; 0 = continuous until stop.
REQ-010 trig  output  1  registered pulse-train output, glitch-free.
REQ-011 busy  output  1  high in every non-IDLE state.
REQ-012 done  output  1  one-cycle strobe on normal train completion.
REQ-013 pulse_cnt  output  NUM_W  number of high phases started in the current or last train.

Function
REQ-014 The FSM SHALL have states IDLE, DELAY (only with REQ-031), HIGH and LOW.
REQ-015 In IDLE with start=1 and stop=0, the block SHALL latch high_cycles, low_cycles and num_pulses, clear pulse_cnt to 1, and enter HIGH; trig SHALL be 1 from the next cycle.
REQ-016 A phase length of 0 SHALL be treated as 1.
REQ-017 trig SHALL remain 1 for exactly the latched high length (H cycles), then 0 for exactly the latched low length (L cycles); period = H+L.
REQ-018 On the end of a LOW phase, the FSM SHALL re-enter HIGH and increment pulse_cnt.
REQ-019 When the high phase of pulse number num_pulses (num_pulses != 0) ends, the FSM SHALL go to IDLE with no trailing low phase, drop trig, and assert done for exactly that one cycle.
REQ-020 With num_pulses=0, pulse_cnt SHALL wrap from all-ones to 0, and the train SHALL never end on its own.
REQ-021 start while busy SHALL be ignored; input changes while busy SHALL have no effect until the next accepted start.
REQ-022 stop=1 in any state SHALL force IDLE and trig=0 at the next edge, with done not asserted and pulse_cnt holding its value.
REQ-023 When start and stop are asserted in the same cycle, stop SHALL win.
REQ-024 A start in the cycle after done SHALL be accepted, giving a minimum inter-train gap of one low cycle.
REQ-025 trig, busy and done SHALL be driven directly from flops.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, trig=0, busy=0, done=0, pulse_cnt=0 and all counters and latched config to 0.
REQ-027 Reset deassertion SHALL take effect at the first clk edge after rst_n rises; no train SHALL start without a fresh start.
REQ-028 Reset mid-train SHALL abort the train immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro PULSE_GEN_DELAY_EN SHALL control a programmable start delay.
REQ-030 With PULSE_GEN_DELAY_EN undefined, there SHALL be no delay port and no DELAY state, and behaviour SHALL be exactly as REQ-015.
REQ-031 With PULSE_GEN_DELAY_EN defined:
- An input port delay_cycles (CNT_W) SHALL be added and latched at start.
- If it is nonzero, the FSM SHALL enter DELAY first, with trig=0 and busy=1 for exactly delay_cycles cycles, then enter HIGH.
- If it is 0, behaviour SHALL be identical to the undefined case.
- stop SHALL abort DELAY per REQ-022.

Verification
REQ-032 high=3, low=2, num=4, start pulse -> trig pattern 111 00 111 00 111 00 111, then done for 1 cycle coincident with trig falling; pulse_cnt=4; busy low afterwards.
REQ-033 high=0, low=0, num=2 -> trig 1 0 1, then done; zero lengths behave as 1.
REQ-034 num=0, high=1, low=1, NUM_W=2 -> continuous toggling; pulse_cnt sequence 1,2,3,0,1; stop mid-HIGH -> trig=0 next cycle, no done.
REQ-035 start and stop in the same IDLE cycle -> no train; start while busy with different high -> original timing unchanged.
REQ-036 rst_n pulled low mid-HIGH between clk edges -> trig and busy fall immediately; first start after release runs a full train.
REQ-037 PULSE_GEN_DELAY_EN defined, delay=5, high=2, num=1 -> busy high 7 cycles, trig high only in the last 2, done after.
